// File: rtl/writeback_arbiter.sv
// writeback_arbiter: merges ALU and buffered LSU results onto the register-file write port, with a busy scoreboard.
// Optional WB_BYPASS_EN adds same-cycle forwarding outputs rs1_fwd/rs2_fwd/fwd_data.
module writeback_arbiter #(
    parameter int XLEN           = 32,
    parameter int REG_ADDR_W     = 5,
    parameter int LSU_FIFO_DEPTH = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              alu_valid,
    input  logic [REG_ADDR_W-1:0]             alu_rd,
    input  logic [XLEN-1:0]                   alu_data,
    input  logic                              lsu_valid,
    output logic                              lsu_ready,
    input  logic [REG_ADDR_W-1:0]             lsu_rd,
    input  logic [XLEN-1:0]                   lsu_data,
    input  logic                              issue_valid,
    input  logic [REG_ADDR_W-1:0]             issue_rd,
    input  logic [REG_ADDR_W-1:0]             query_rs1,
    input  logic [REG_ADDR_W-1:0]             query_rs2,
    output logic                              rs1_busy,
    output logic                              rs2_busy,
    output logic                              regWrite,
    output logic [REG_ADDR_W-1:0]             writeRegister,
    output logic [XLEN-1:0]                   writeData,
    output logic [$clog2(LSU_FIFO_DEPTH):0]   fifo_count
`ifdef WB_BYPASS_EN
    ,
    output logic                              rs1_fwd,
    output logic                              rs2_fwd,
    output logic [XLEN-1:0]                   fwd_data
`endif
);
    localparam int PW = $clog2(LSU_FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int NR = 2 ** REG_ADDR_W;

    logic [REG_ADDR_W-1:0] fifo_rd   [LSU_FIFO_DEPTH];
    logic [XLEN-1:0]       fifo_data [LSU_FIFO_DEPTH];
    logic [PW-1:0]         wp, rp;
    logic [NR-1:0]         busy, set_mask, clr_mask;
    logic                  push, pop;
    logic [REG_ADDR_W-1:0] head_rd;

    assign lsu_ready = fifo_count < CW'(LSU_FIFO_DEPTH);
    assign push      = lsu_valid && lsu_ready;
    assign pop       = !alu_valid && fifo_count != '0;
    assign head_rd   = fifo_rd[rp];
    assign set_mask  = issue_valid ? NR'(1) << issue_rd : '0;
    assign clr_mask  = pop ? NR'(1) << head_rd : '0;
    assign rs1_busy  = busy[query_rs1];
    assign rs2_busy  = busy[query_rs2];

    // Storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[wp]   <= lsu_rd;
            fifo_data[wp] <= lsu_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp            <= '0;
            rp            <= '0;
            fifo_count    <= '0;
            busy          <= '0;
            regWrite      <= 1'b0;
            writeRegister <= '0;
            writeData     <= '0;
        end else begin
            wp            <= push ? wp + PW'(1) : wp;
            rp            <= pop ? rp + PW'(1) : rp;
            fifo_count    <= fifo_count + CW'(push) - CW'(pop);
            // Set is applied after clear so a same-edge reissue keeps the register busy.
            busy          <= ((busy & ~clr_mask) | set_mask) & ~NR'(1);
            regWrite      <= alu_valid ? alu_rd != '0 : pop && head_rd != '0;
            writeRegister <= alu_valid ? alu_rd : pop ? head_rd : writeRegister;
            writeData     <= alu_valid ? alu_data : pop ? fifo_data[rp] : writeData;
        end
    end

`ifdef WB_BYPASS_EN
    assign rs1_fwd  = regWrite && writeRegister != '0 && writeRegister == query_rs1;
    assign rs2_fwd  = regWrite && writeRegister != '0 && writeRegister == query_rs2;
    assign fwd_data = writeData;
`endif
endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter: directed and randomized checks of writeback_arbiter against a queue-based reference model.
module tb_writeback_arbiter;
    localparam int D = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        alu_valid = 1'b0, lsu_valid = 1'b0, issue_valid = 1'b0;
    logic [4:0]  alu_rd = '0, lsu_rd = '0, issue_rd = '0, query_rs1 = '0, query_rs2 = '0;
    logic [31:0] alu_data = '0, lsu_data = '0;
    logic        lsu_ready, rs1_busy, rs2_busy, regWrite;
    logic [4:0]  writeRegister;
    logic [31:0] writeData;
    logic [1:0]  fifo_count;
`ifdef WB_BYPASS_EN
    logic        rs1_fwd, rs2_fwd;
    logic [31:0] fwd_data;
`endif

    int checks = 0;
    int failures = 0;

    writeback_arbiter #(.XLEN(32), .REG_ADDR_W(5), .LSU_FIFO_DEPTH(D)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .query_rs1(query_rs1), .query_rs2(query_rs2),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .regWrite(regWrite), .writeRegister(writeRegister), .writeData(writeData),
        .fifo_count(fifo_count)
`ifdef WB_BYPASS_EN
        , .rs1_fwd(rs1_fwd), .rs2_fwd(rs2_fwd), .fwd_data(fwd_data)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: pending LSU results as a queue, busy set as a plain array.
    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;
    ent_t        q[$];
    logic        mbusy[32];
    logic        exp_we;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            q.delete();
            foreach (mbusy[i]) mbusy[i] = 1'b0;
            exp_we = 1'b0;
            exp_rd = '0;
            exp_data = '0;
        end else begin
            bit   rdy;
            ent_t e;
            rdy = q.size() < D;
            if (alu_valid) begin
                exp_we = alu_rd != 0; exp_rd = alu_rd; exp_data = alu_data;
            end else if (q.size() > 0) begin
                e = q.pop_front();
                exp_we = e.rd != 0; exp_rd = e.rd; exp_data = e.data;
                mbusy[e.rd] = 1'b0;
            end else begin
                exp_we = 1'b0;
            end
            if (issue_valid && issue_rd != 0) mbusy[issue_rd] = 1'b1;
            if (lsu_valid && rdy) q.push_back('{lsu_rd, lsu_data});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 1'b0; lsu_valid = 1'b0; issue_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h1234;
        lsu_valid = 1'b1; lsu_rd = 5'd10; issue_valid = 1'b1; issue_rd = 5'd11; query_rs1 = 5'd11;
        cyc(); cyc();
        checks++; if (regWrite !== 1'b0) begin failures++; $display("FAIL reset_we got=%0b exp=0", regWrite); end
        checks++; if (writeRegister !== 5'd0 || writeData !== 32'd0) begin failures++; $display("FAIL reset_wr got=%0d/%h exp=0/0", writeRegister, writeData); end
        checks++; if (fifo_count !== 2'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
        checks++; if (lsu_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b exp=1", lsu_ready); end
        checks++; if (rs1_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", rs1_busy); end
        idle();
        reset = 1'b1;
        cyc();
    endtask

    task automatic test_alu();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        cyc();
        idle();
        checks++; if (regWrite !== 1'b1 || writeRegister !== 5'd5 || writeData !== 32'hDEADBEEF) begin
            failures++; $display("FAIL alu_write got=%0b/%0d/%h exp=1/5/deadbeef", regWrite, writeRegister, writeData); end
        cyc();
        checks++; if (regWrite !== 1'b0) begin failures++; $display("FAIL alu_idle got=%0b exp=0", regWrite); end
    endtask

    task automatic test_lsu_vs_alu();
        issue_valid = 1'b1; issue_rd = 5'd7; query_rs1 = 5'd7;
        cyc();
        issue_valid = 1'b0;
        checks++; if (rs1_busy !== 1'b1) begin failures++; $display("FAIL issue_busy got=%0b exp=1", rs1_busy); end
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h11;
        cyc();
        lsu_valid = 1'b0;
        checks++; if (regWrite !== 1'b1 || writeRegister !== 5'd3 || fifo_count !== 2'd1 || rs1_busy !== 1'b1) begin
            failures++; $display("FAIL prio_1 got=%0b/%0d/cnt%0d/busy%0b exp=1/3/cnt1/busy1", regWrite, writeRegister, fifo_count, rs1_busy); end
        cyc();
        alu_valid = 1'b0;
        checks++; if (regWrite !== 1'b1 || writeRegister !== 5'd3 || rs1_busy !== 1'b1) begin
            failures++; $display("FAIL prio_2 got=%0b/%0d/busy%0b exp=1/3/busy1", regWrite, writeRegister, rs1_busy); end
        cyc();
        checks++; if (regWrite !== 1'b1 || writeRegister !== 5'd7 || writeData !== 32'h11 || rs1_busy !== 1'b0 || fifo_count !== 2'd0) begin
            failures++; $display("FAIL lsu_write got=%0b/%0d/%h/busy%0b/cnt%0d exp=1/7/11/busy0/cnt0", regWrite, writeRegister, writeData, rs1_busy, fifo_count); end
        cyc();
    endtask

    task automatic test_full_fifo();
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h1;
        lsu_valid = 1'b1; lsu_rd = 5'd8; lsu_data = 32'h88;
        cyc();
        lsu_rd = 5'd9; lsu_data = 32'h99;
        cyc();
        lsu_rd = 5'd10; lsu_data = 32'hAA;
        checks++; if (lsu_ready !== 1'b0 || fifo_count !== 2'd2) begin
            failures++; $display("FAIL full got=rdy%0b/cnt%0d exp=rdy0/cnt2", lsu_ready, fifo_count); end
        cyc();
        checks++; if (fifo_count !== 2'd2) begin failures++; $display("FAIL full_reject got=%0d exp=2", fifo_count); end
        alu_valid = 1'b0;
        #1;
        checks++; if (lsu_ready !== 1'b0) begin failures++; $display("FAIL full_pop_ready got=%0b exp=0", lsu_ready); end
        cyc();
        lsu_valid = 1'b0;
        checks++; if (regWrite !== 1'b1 || writeRegister !== 5'd8 || writeData !== 32'h88 || fifo_count !== 2'd1 || lsu_ready !== 1'b1) begin
            failures++; $display("FAIL drain_8 got=%0b/%0d/%h/cnt%0d/rdy%0b exp=1/8/88/cnt1/rdy1", regWrite, writeRegister, writeData, fifo_count, lsu_ready); end
        cyc();
        checks++; if (regWrite !== 1'b1 || writeRegister !== 5'd9 || writeData !== 32'h99 || fifo_count !== 2'd0) begin
            failures++; $display("FAIL drain_9 got=%0b/%0d/%h/cnt%0d exp=1/9/99/cnt0", regWrite, writeRegister, writeData, fifo_count); end
        cyc();
    endtask

    task automatic test_edges();
        lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'h5;
        cyc();
        lsu_valid = 1'b0;
        checks++; if (fifo_count !== 2'd1) begin failures++; $display("FAIL rd0_push got=%0d exp=1", fifo_count); end
        cyc();
        checks++; if (regWrite !== 1'b0 || fifo_count !== 2'd0) begin
            failures++; $display("FAIL rd0_pop got=%0b/cnt%0d exp=0/cnt0", regWrite, fifo_count); end
        issue_valid = 1'b1; issue_rd = 5'd4; query_rs1 = 5'd4;
        cyc();
        issue_valid = 1'b0; lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h44;
        cyc();
        lsu_valid = 1'b0; issue_valid = 1'b1; issue_rd = 5'd4;
        cyc();
        issue_valid = 1'b0;
        checks++; if (regWrite !== 1'b1 || writeRegister !== 5'd4 || rs1_busy !== 1'b1) begin
            failures++; $display("FAIL set_wins got=%0b/%0d/busy%0b exp=1/4/busy1", regWrite, writeRegister, rs1_busy); end
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h1;
        issue_valid = 1'b1; issue_rd = 5'd13; query_rs2 = 5'd13;
        lsu_valid = 1'b1; lsu_rd = 5'd11;
        cyc();
        issue_valid = 1'b0; lsu_rd = 5'd12;
        cyc();
        lsu_valid = 1'b0;
        checks++; if (fifo_count !== 2'd2 || rs2_busy !== 1'b1) begin
            failures++; $display("FAIL pre_reset got=cnt%0d/busy%0b exp=cnt2/busy1", fifo_count, rs2_busy); end
        #2 reset = 1'b0;
        #1;
        checks++; if (fifo_count !== 2'd0 || lsu_ready !== 1'b1 || rs1_busy !== 1'b0 || rs2_busy !== 1'b0 || regWrite !== 1'b0) begin
            failures++; $display("FAIL mid_reset got=cnt%0d/rdy%0b/b%0b%0b/we%0b exp=cnt0/rdy1/b00/we0", fifo_count, lsu_ready, rs1_busy, rs2_busy, regWrite); end
        idle();
        reset = 1'b1;
        cyc();
        checks++; if (regWrite !== 1'b0 || fifo_count !== 2'd0) begin
            failures++; $display("FAIL post_reset got=%0b/cnt%0d exp=0/cnt0", regWrite, fifo_count); end
    endtask

`ifdef WB_BYPASS_EN
    task automatic test_bypass();
        alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 32'h42;
        cyc();
        alu_valid = 1'b0; query_rs1 = 5'd6;
        #1;
        checks++; if (rs1_fwd !== 1'b1 || fwd_data !== 32'h42) begin
            failures++; $display("FAIL fwd got=%0b/%h exp=1/42", rs1_fwd, fwd_data); end
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h7;
        cyc();
        alu_valid = 1'b0; query_rs1 = 5'd0;
        #1;
        checks++; if (rs1_fwd !== 1'b0) begin failures++; $display("FAIL fwd_rd0 got=%0b exp=0", rs1_fwd); end
        cyc();
    endtask
`endif

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            logic [4:0] r;
            alu_valid = $urandom_range(0, 9) < 4;
            alu_rd    = 5'($urandom_range(0, 31));
            alu_data  = $urandom;
            lsu_valid = $urandom_range(0, 1) == 1;
            lsu_rd    = 5'($urandom_range(0, 31));
            lsu_data  = $urandom;
            r = 5'($urandom_range(0, 31));
            issue_valid = $urandom_range(0, 3) == 0 && !mbusy[r];
            issue_rd  = r;
            query_rs1 = 5'($urandom_range(0, 31));
            query_rs2 = 5'($urandom_range(0, 31));
            #1;
            checks++; if (lsu_ready !== (q.size() < D) || rs1_busy !== mbusy[query_rs1] || rs2_busy !== mbusy[query_rs2]) begin
                failures++; $display("FAIL rand_comb n=%0d got=rdy%0b/b%0b%0b exp=rdy%0b/b%0b%0b", n, lsu_ready, rs1_busy, rs2_busy, q.size() < D, mbusy[query_rs1], mbusy[query_rs2]); end
            cyc();
            checks++; if (regWrite !== exp_we || (exp_we && (writeRegister !== exp_rd || writeData !== exp_data)) || fifo_count !== 2'(q.size())) begin
                failures++; $display("FAIL rand_wb n=%0d got=%0b/%0d/%h/cnt%0d exp=%0b/%0d/%h/cnt%0d", n, regWrite, writeRegister, writeData, fifo_count, exp_we, exp_rd, exp_data, q.size()); end
        end
        idle();
        cyc(); cyc(); cyc();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_lsu_vs_alu();
        test_full_fifo();
        test_edges();
`ifdef WB_BYPASS_EN
        test_bypass();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
